mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request/response channel shared by the fetch, data and downstream memory ports.
// master drives the request side; slave answers with ready, read data and response.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    logic              valid;
    logic              ready;
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        size;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] data_read;
    logic [1:0]        resp;

    modport master (
        output valid, req, addr, size, data_write,
        input  ready, data_read, resp
    );

    modport slave (
        input  valid, req, addr, size, data_write,
        output ready, data_read, resp
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between a fetch and a data requester,
// with a per-transfer wait timeout that answers the requester with resp=2'b10.
module mem_port_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  if_port,
    mem_port_arbiter_if.slave  mem_port,
    mem_port_arbiter_if.master rw_port
);
    // state   | meaning
    // IDLE    | no transfer outstanding, arbitrating between requesters
    // GNT_IF  | fetch transfer presented downstream, waiting for rw_ready
    // GNT_MEM | data transfer presented downstream, waiting for rw_ready
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              last_winner_q, last_winner_d;
    logic [7:0]        wait_q, wait_d;
    logic              rw_valid_q, rw_valid_d;
    logic              rw_req_q, rw_req_d;
    logic [ADDR_W-1:0] rw_addr_q, rw_addr_d;
    logic [1:0]        rw_size_q, rw_size_d;
    logic [DATA_W-1:0] rw_data_write_q, rw_data_write_d;

    logic              pick_mem;
    logic              timed_out;
    logic              done;
    logic [DATA_W-1:0] done_data;
    logic [1:0]        done_resp;

    // Fetches never write, so their req/write-data fields are intentionally ignored.
    logic unused_fetch_fields;
    assign unused_fetch_fields = if_port.req ^ (^if_port.data_write);

    always_comb begin
        state_d         = state_q;
        last_winner_d   = last_winner_q;
        wait_d          = wait_q;
        rw_valid_d      = rw_valid_q;
        rw_req_d        = rw_req_q;
        rw_addr_d       = rw_addr_q;
        rw_size_d       = rw_size_q;
        rw_data_write_d = rw_data_write_q;
        pick_mem        = 1'b0;
        timed_out       = 1'b0;
        done            = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_port.valid && mem_port.valid) begin
                    pick_mem = ~last_winner_q;
                end else begin
                    pick_mem = mem_port.valid;
                end
                if (if_port.valid || mem_port.valid) begin
                    wait_d     = 8'd0;
                    rw_valid_d = 1'b1;
                    if (pick_mem) begin
                        state_d         = GNT_MEM;
                        rw_req_d        = mem_port.req;
                        rw_addr_d       = mem_port.addr;
                        rw_size_d       = mem_port.size;
                        rw_data_write_d = mem_port.data_write;
                    end else begin
                        state_d         = GNT_IF;
                        rw_req_d        = 1'b0;
                        rw_addr_d       = if_port.addr;
                        rw_size_d       = if_port.size;
                        rw_data_write_d = '0;
                    end
                end
            end
            GNT_IF, GNT_MEM: begin
                timed_out = !rw_port.ready && (wait_q == TIMEOUT_CNT);
                done      = rw_port.ready || timed_out;
                if (done) begin
                    state_d       = IDLE;
                    rw_valid_d    = 1'b0;
                    last_winner_d = (state_q == GNT_MEM);
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d    = IDLE;
                rw_valid_d = 1'b0;
            end
        endcase
    end

    // Completion data/resp reach only the granted requester, and only in its ready cycle.
    always_comb begin
        done_data          = rw_port.ready ? rw_port.data_read : '0;
        done_resp          = rw_port.ready ? rw_port.resp : (timed_out ? 2'b10 : 2'b00);
        if_port.ready      = done && (state_q == GNT_IF);
        if_port.data_read  = (done && (state_q == GNT_IF)) ? done_data : '0;
        if_port.resp       = (done && (state_q == GNT_IF)) ? done_resp : 2'b00;
        mem_port.ready     = done && (state_q == GNT_MEM);
        mem_port.data_read = (done && (state_q == GNT_MEM)) ? done_data : '0;
        mem_port.resp      = (done && (state_q == GNT_MEM)) ? done_resp : 2'b00;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            last_winner_q   <= 1'b1;
            wait_q          <= 8'd0;
            rw_valid_q      <= 1'b0;
            rw_req_q        <= 1'b0;
            rw_addr_q       <= '0;
            rw_size_q       <= 2'b00;
            rw_data_write_q <= '0;
        end else begin
            state_q         <= state_d;
            last_winner_q   <= last_winner_d;
            wait_q          <= wait_d;
            rw_valid_q      <= rw_valid_d;
            rw_req_q        <= rw_req_d;
            rw_addr_q       <= rw_addr_d;
            rw_size_q       <= rw_size_d;
            rw_data_write_q <= rw_data_write_d;
        end
    end

    assign rw_port.valid      = rw_valid_q;
    assign rw_port.req        = rw_req_q;
    assign rw_port.addr       = rw_addr_q;
    assign rw_port.size       = rw_size_q;
    assign rw_port.data_write = rw_data_write_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model predicts every output each cycle,
// and literal expectations pin the key scenarios (latency, round-robin, write hold, timeout, reset).
module tb_mem_port_arbiter;
    localparam int TO = 4;

    logic clock;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) if_bus  ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) mem_bus ();
    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) rw_bus  ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .if_port  (if_bus),
        .mem_port (mem_bus),
        .rw_port  (rw_bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: who owns the port (0 none, 1 fetch, 2 data), what was latched, how long it has waited.
    int          m_owner;
    logic        m_last_data;
    int          m_wait;
    logic [63:0] m_addr;
    logic [1:0]  m_size;
    logic        m_req;
    logic [63:0] m_wdata;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_owner     <= 0;
            m_last_data <= 1'b1;
            m_wait      <= 0;
            m_addr      <= '0;
            m_size      <= '0;
            m_req       <= 1'b0;
            m_wdata     <= '0;
        end else if (m_owner == 0) begin
            if (if_bus.valid && (!mem_bus.valid || m_last_data)) begin
                m_owner <= 1;
                m_addr  <= if_bus.addr;
                m_size  <= if_bus.size;
                m_req   <= 1'b0;
                m_wdata <= '0;
                m_wait  <= 0;
            end else if (mem_bus.valid) begin
                m_owner <= 2;
                m_addr  <= mem_bus.addr;
                m_size  <= mem_bus.size;
                m_req   <= mem_bus.req;
                m_wdata <= mem_bus.data_write;
                m_wait  <= 0;
            end
        end else if (rw_bus.ready || m_wait == TO) begin
            m_last_data <= (m_owner == 2);
            m_owner     <= 0;
        end else begin
            m_wait <= m_wait + 1;
        end
    end

    logic        e_fin;
    logic [63:0] e_data;
    logic [1:0]  e_resp;

    always @(negedge clock) begin
        e_fin  = (m_owner != 0) && (rw_bus.ready || m_wait == TO);
        e_data = rw_bus.ready ? rw_bus.data_read : 64'h0;
        e_resp = rw_bus.ready ? rw_bus.resp : 2'b10;
        check("rw_valid",      rw_bus.valid,      (m_owner != 0));
        check("rw_req",        rw_bus.req,        m_req);
        check("rw_addr",       rw_bus.addr,       m_addr);
        check("rw_size",       rw_bus.size,       m_size);
        check("rw_data_write", rw_bus.data_write, m_wdata);
        check("if_ready",      if_bus.ready,      e_fin && m_owner == 1);
        check("if_data_read",  if_bus.data_read,  (e_fin && m_owner == 1) ? e_data : 64'h0);
        check("if_resp",       if_bus.resp,       (e_fin && m_owner == 1) ? e_resp : 2'b00);
        check("mem_ready",     mem_bus.ready,     e_fin && m_owner == 2);
        check("mem_data_read", mem_bus.data_read, (e_fin && m_owner == 2) ? e_data : 64'h0);
        check("mem_resp",      mem_bus.resp,      (e_fin && m_owner == 2) ? e_resp : 2'b00);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        if_bus.valid       = 1'b0;
        if_bus.req         = 1'b0;
        if_bus.addr        = '0;
        if_bus.size        = '0;
        if_bus.data_write  = '0;
        mem_bus.valid      = 1'b0;
        mem_bus.req        = 1'b0;
        mem_bus.addr       = '0;
        mem_bus.size       = '0;
        mem_bus.data_write = '0;
        rw_bus.ready       = 1'b0;
        rw_bus.data_read   = '0;
        rw_bus.resp        = '0;
        step();
        step();
        @(negedge clock);
        check("rst_rw_valid", rw_bus.valid, 0);
        check("rst_if_ready", if_bus.ready, 0);
        check("rst_mem_ready", mem_bus.ready, 0);
        step();
        reset = 1'b0;

        // single fetch, ready on third granted cycle
        if_bus.valid = 1'b1;
        if_bus.addr  = 64'h8000_0000;
        if_bus.size  = 2'b11;
        step();
        @(negedge clock);
        check("fetch_latency_valid", rw_bus.valid, 1);
        check("fetch_addr", rw_bus.addr, 64'h8000_0000);
        check("fetch_req", rw_bus.req, 0);
        step();
        step();
        rw_bus.ready     = 1'b1;
        rw_bus.data_read = 64'h13;
        @(negedge clock);
        check("fetch_ready", if_bus.ready, 1);
        check("fetch_data", if_bus.data_read, 64'h13);
        check("fetch_resp", if_bus.resp, 0);
        check("fetch_mem_ready", mem_bus.ready, 0);
        step();
        rw_bus.ready     = 1'b0;
        rw_bus.data_read = 64'h0;
        if_bus.valid     = 1'b0;
        @(negedge clock);
        check("fetch_idle_valid", rw_bus.valid, 0);
        check("fetch_single_pulse", if_bus.ready, 0);

        // stray ready while idle
        rw_bus.ready     = 1'b1;
        rw_bus.data_read = 64'h55;
        @(negedge clock);
        check("stray_if_ready", if_bus.ready, 0);
        check("stray_mem_ready", mem_bus.ready, 0);
        step();
        @(negedge clock);
        check("stray_no_grant", rw_bus.valid, 0);
        rw_bus.ready = 1'b0;

        // data write, payload held while requester inputs change
        mem_bus.valid      = 1'b1;
        mem_bus.req        = 1'b1;
        mem_bus.addr       = 64'h8000_1000;
        mem_bus.size       = 2'b10;
        mem_bus.data_write = 64'hDEAD_BEEF;
        step();
        @(negedge clock);
        check("wr_req", rw_bus.req, 1);
        check("wr_data", rw_bus.data_write, 64'hDEAD_BEEF);
        check("wr_addr", rw_bus.addr, 64'h8000_1000);
        step();
        mem_bus.data_write = 64'h1234;
        mem_bus.addr       = 64'h0;
        step();
        rw_bus.ready     = 1'b1;
        rw_bus.resp      = 2'b01;
        rw_bus.data_read = 64'h77;
        @(negedge clock);
        check("wr_hold_data", rw_bus.data_write, 64'hDEAD_BEEF);
        check("wr_hold_addr", rw_bus.addr, 64'h8000_1000);
        check("wr_mem_ready", mem_bus.ready, 1);
        check("wr_mem_resp", mem_bus.resp, 2'b01);
        check("wr_if_ready", if_bus.ready, 0);
        step();
        rw_bus.ready  = 1'b0;
        rw_bus.resp   = 2'b00;
        mem_bus.valid = 1'b0;
        mem_bus.req   = 1'b0;

        // tie after reset: fetch first, then alternate
        reset = 1'b1;
        step();
        reset              = 1'b0;
        if_bus.valid       = 1'b1;
        if_bus.addr        = 64'h1000;
        if_bus.size        = 2'b10;
        mem_bus.valid      = 1'b1;
        mem_bus.addr       = 64'h2000;
        mem_bus.size       = 2'b01;
        mem_bus.data_write = 64'hAAAA;
        step();
        rw_bus.ready     = 1'b1;
        rw_bus.data_read = 64'h11;
        @(negedge clock);
        check("tie1_addr", rw_bus.addr, 64'h1000);
        check("tie1_if_ready", if_bus.ready, 1);
        check("tie1_mem_ready", mem_bus.ready, 0);
        step();
        rw_bus.ready = 1'b0;
        if_bus.valid = 1'b0;
        @(negedge clock);
        check("tie_gap_valid", rw_bus.valid, 0);
        step();
        if_bus.valid = 1'b1;
        rw_bus.ready = 1'b1;
        @(negedge clock);
        check("tie2_addr", rw_bus.addr, 64'h2000);
        check("tie2_wdata", rw_bus.data_write, 64'hAAAA);
        check("tie2_mem_ready", mem_bus.ready, 1);
        step();
        rw_bus.ready = 1'b0;
        step();
        @(negedge clock);
        check("tie3_fetch_again", rw_bus.addr, 64'h1000);
        rw_bus.ready = 1'b1;
        step();
        rw_bus.ready = 1'b0;
        if_bus.valid = 1'b0;
        step();
        @(negedge clock);
        check("tie4_data_again", rw_bus.addr, 64'h2000);
        rw_bus.ready = 1'b1;
        step();
        rw_bus.ready  = 1'b0;
        mem_bus.valid = 1'b0;

        // timeout: downstream never answers
        if_bus.valid     = 1'b1;
        if_bus.addr      = 64'h3000;
        rw_bus.data_read = 64'hFFFF;
        rw_bus.resp      = 2'b01;
        step();
        step();
        step();
        step();
        @(negedge clock);
        check("to_not_yet", if_bus.ready, 0);
        step();
        @(negedge clock);
        check("to_ready", if_bus.ready, 1);
        check("to_resp", if_bus.resp, 2'b10);
        check("to_data", if_bus.data_read, 64'h0);
        step();
        if_bus.valid = 1'b0;
        @(negedge clock);
        check("to_idle", rw_bus.valid, 0);

        // reset asserted mid GNT_MEM
        mem_bus.valid      = 1'b1;
        mem_bus.req        = 1'b1;
        mem_bus.addr       = 64'h4000;
        mem_bus.data_write = 64'h99;
        step();
        step();
        rw_bus.ready = 1'b1;
        reset        = 1'b1;
        #1;
        check("rstmid_rw_valid", rw_bus.valid, 0);
        check("rstmid_mem_ready", mem_bus.ready, 0);
        check("rstmid_mem_resp", mem_bus.resp, 0);
        step();
        reset         = 1'b0;
        rw_bus.ready  = 1'b0;
        mem_bus.valid = 1'b0;
        step();
        step();
        @(negedge clock);
        check("rstmid_after_valid", rw_bus.valid, 0);
        check("rstmid_after_addr", rw_bus.addr, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
